// File: rtl/cdb_execute_unit.sv
// Execute stage behind the reservation station: 1-stage ALU and 3-stage MUL
// paths feed a writeback FIFO that broadcasts one result per cycle on the CDB.
module cdb_execute_unit #(
  parameter int WBQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [123:0] issue_pkt,
  output logic [31:0]  ALU_result,
  output logic [6:0]   ALU_result_dest,
  output logic         ALU_result_valid,
  output logic [31:0]  cdb_pc,
  output logic         busy,
  output logic         wbq_overflow
);

  localparam int PW = $clog2(WBQ_DEPTH);
  localparam logic [PW:0] DepthC = (PW+1)'(WBQ_DEPTH);
  localparam logic [6:0] OpMul = 7'h0B;

  logic        e1_valid_q, e1_valid_d;
  logic [6:0]  e1_op_q, e1_op_d, e1_rd_q, e1_rd_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_a_q, e1_a_d, e1_b_q, e1_b_d;

  logic        m2_valid_q, m2_valid_d, m3_valid_q, m3_valid_d;
  logic [31:0] m2_res_q, m2_res_d, m3_res_q, m3_res_d;
  logic [6:0]  m2_rd_q, m2_rd_d, m3_rd_q, m3_rd_d;
  logic [31:0] m2_pc_q, m2_pc_d, m3_pc_q, m3_pc_d;

  logic [70:0]   wbq_q [WBQ_DEPTH];
  logic [70:0]   wbq_d [WBQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic        out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [31:0] out_res_q, out_res_d, out_pc_q, out_pc_d;
  logic [6:0]  out_rd_q, out_rd_d;

  logic [31:0] alu_res;
  logic [31:0] mul_res;
  logic        push_alu;

  function automatic logic [31:0] alu_op(input logic [6:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      7'h01: r = a + b;
      7'h02: r = a - b;
      7'h03: r = a & b;
      7'h04: r = a | b;
      7'h05: r = a ^ b;
      7'h06: r = a << b[4:0];
      7'h07: r = a >> b[4:0];
      7'h08: r = $signed(a) >>> b[4:0];
      7'h09: r = {31'd0, $signed(a) < $signed(b)};
      7'h0A: r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign alu_res  = alu_op(e1_op_q, e1_a_q, e1_b_q);
  assign mul_res  = e1_a_q * e1_b_q;
  assign push_alu = e1_valid_q && (e1_op_q != OpMul);

  always_comb begin
    e1_valid_d = (issue_pkt[123:117] != 7'd0);
    e1_op_d    = issue_pkt[123:117];
    e1_pc_d    = issue_pkt[116:85];
    e1_rd_d    = issue_pkt[84:78];
    e1_a_d     = issue_pkt[63:32];
    e1_b_d     = issue_pkt[31:0];

    m2_valid_d = e1_valid_q && (e1_op_q == OpMul);
    m2_res_d   = mul_res;
    m2_rd_d    = e1_rd_q;
    m2_pc_d    = e1_pc_q;
    m3_valid_d = m2_valid_q;
    m3_res_d   = m2_res_q;
    m3_rd_d    = m2_rd_q;
    m3_pc_d    = m2_pc_q;
  end

  // Pop first so its slot is reusable, then enqueue MUL (older) before ALU.
  always_comb begin
    wbq_d       = wbq_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_res_d   = out_res_q;
    out_rd_d    = out_rd_q;
    out_pc_d    = out_pc_q;
    ovf_d       = ovf_q;

    if (count_q != '0) begin
      out_valid_d = 1'b1;
      {out_res_d, out_rd_d, out_pc_d} = wbq_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end

    if (m3_valid_q) begin
      if (count_d < DepthC) begin
        wbq_d[wr_ptr_d] = {m3_res_q, m3_rd_q, m3_pc_q};
        wr_ptr_d = wr_ptr_d + 1'b1;
        count_d  = count_d + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (push_alu) begin
      if (count_d < DepthC) begin
        wbq_d[wr_ptr_d] = {alu_res, e1_rd_q, e1_pc_q};
        wr_ptr_d = wr_ptr_d + 1'b1;
        count_d  = count_d + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e1_valid_q <= 1'b0; e1_op_q <= '0; e1_rd_q <= '0;
      e1_pc_q <= '0; e1_a_q <= '0; e1_b_q <= '0;
      m2_valid_q <= 1'b0; m2_res_q <= '0; m2_rd_q <= '0; m2_pc_q <= '0;
      m3_valid_q <= 1'b0; m3_res_q <= '0; m3_rd_q <= '0; m3_pc_q <= '0;
      for (int i = 0; i < WBQ_DEPTH; i++) wbq_q[i] <= '0;
      rd_ptr_q <= '0; wr_ptr_q <= '0; count_q <= '0;
      out_valid_q <= 1'b0; out_res_q <= '0; out_rd_q <= '0; out_pc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      e1_valid_q <= e1_valid_d; e1_op_q <= e1_op_d; e1_rd_q <= e1_rd_d;
      e1_pc_q <= e1_pc_d; e1_a_q <= e1_a_d; e1_b_q <= e1_b_d;
      m2_valid_q <= m2_valid_d; m2_res_q <= m2_res_d; m2_rd_q <= m2_rd_d; m2_pc_q <= m2_pc_d;
      m3_valid_q <= m3_valid_d; m3_res_q <= m3_res_d; m3_rd_q <= m3_rd_d; m3_pc_q <= m3_pc_d;
      wbq_q <= wbq_d;
      rd_ptr_q <= rd_ptr_d; wr_ptr_q <= wr_ptr_d; count_q <= count_d;
      out_valid_q <= out_valid_d; out_res_q <= out_res_d;
      out_rd_q <= out_rd_d; out_pc_q <= out_pc_d;
      ovf_q <= ovf_d;
    end
  end

  assign ALU_result       = out_res_q;
  assign ALU_result_dest  = out_rd_q;
  assign ALU_result_valid = out_valid_q;
  assign cdb_pc           = out_pc_q;
  assign wbq_overflow     = ovf_q;
  assign busy = e1_valid_q | m2_valid_q | m3_valid_q | (count_q != '0);

endmodule

// File: tb/tb_cdb_execute_unit.sv
// Bench for cdb_execute_unit: directed scenarios plus random issue, checked
// against a completion-time/FIFO model of the broadcast stream.
module tb_cdb_execute_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [123:0] issue_pkt;
  logic [31:0]  ALU_result;
  logic [6:0]   ALU_result_dest;
  logic         ALU_result_valid;
  logic [31:0]  cdb_pc;
  logic         busy;
  logic         wbq_overflow;

  cdb_execute_unit #(.WBQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .issue_pkt(issue_pkt),
    .ALU_result(ALU_result), .ALU_result_dest(ALU_result_dest),
    .ALU_result_valid(ALU_result_valid), .cdb_pc(cdb_pc),
    .busy(busy), .wbq_overflow(wbq_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [6:0]  rd;
    logic [31:0] pc;
    int          pushEdge;
  } item_t;

  item_t       inflight[$];
  item_t       wbq[$];
  int          edgeNo = 0;
  logic        expValid = 1'b0;
  logic [31:0] expRes = '0;
  logic [31:0] expPc = '0;
  logic [6:0]  expDest = '0;
  logic        expOvf = 1'b0;

  function automatic logic [31:0] refResult(input logic [6:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    logic [63:0] prod;
    sh = b[4:0];
    sa = a;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      7'h01: return a + b;
      7'h02: return a - b;
      7'h03: return a & b;
      7'h04: return a | b;
      7'h05: return a ^ b;
      7'h06: return a << sh;
      7'h07: return a >> sh;
      7'h08: return sa >>> sh;
      7'h09: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7'h0A: return (a < b) ? 32'd1 : 32'd0;
      7'h0B: return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [123:0] mkPkt(input logic [6:0] op, input logic [31:0] pc,
                                         input logic [6:0] rd, input logic [31:0] a,
                                         input logic [31:0] b);
    return {op, pc, rd, 7'd0, 7'd0, a, b};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic expBusy;
    expBusy = (inflight.size() > 0) || (wbq.size() > 0);
    checkVal({tag, "_valid"}, {31'd0, ALU_result_valid}, {31'd0, expValid});
    checkVal({tag, "_result"}, ALU_result, expRes);
    checkVal({tag, "_dest"}, {25'd0, ALU_result_dest}, {25'd0, expDest});
    checkVal({tag, "_pc"}, cdb_pc, expPc);
    checkVal({tag, "_busy"}, {31'd0, busy}, {31'd0, expBusy});
    checkVal({tag, "_ovf"}, {31'd0, wbq_overflow}, {31'd0, expOvf});
  endtask

  // One clock edge of the reference: broadcast the queue head, enqueue
  // everything completing now in issue order, then record the new issue.
  task automatic modelEdge(input logic [123:0] pkt);
    item_t h;
    item_t n;
    if (wbq.size() > 0) begin
      h = wbq.pop_front();
      expValid = 1'b1;
      expRes = h.res;
      expDest = h.rd;
      expPc = h.pc;
    end else begin
      expValid = 1'b0;
    end
    for (int i = 0; i < inflight.size(); ) begin
      if (inflight[i].pushEdge == edgeNo) begin
        wbq.push_back(inflight[i]);
        inflight.delete(i);
      end else begin
        i++;
      end
    end
    while (wbq.size() > 4) begin
      void'(wbq.pop_back());
      expOvf = 1'b1;
    end
    if (pkt[123:117] != 7'd0) begin
      n.res = refResult(pkt[123:117], pkt[63:32], pkt[31:0]);
      n.rd = pkt[84:78];
      n.pc = pkt[116:85];
      n.pushEdge = edgeNo + ((pkt[123:117] == 7'h0B) ? 3 : 1);
      inflight.push_back(n);
    end
    edgeNo++;
  endtask

  task automatic modelReset();
    inflight.delete();
    wbq.delete();
    expValid = 1'b0;
    expRes = '0;
    expDest = '0;
    expPc = '0;
    expOvf = 1'b0;
  endtask

  task automatic applyStimulus(input logic [123:0] pkt);
    issue_pkt = pkt;
    @(posedge clk);
    modelEdge(pkt);
    #1;
    checkOutput($sformatf("e%0d", edgeNo));
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_valid"}, {31'd0, ALU_result_valid}, 32'd0);
    checkVal({tag, "_result"}, ALU_result, 32'd0);
    checkVal({tag, "_dest"}, {25'd0, ALU_result_dest}, 32'd0);
    checkVal({tag, "_pc"}, cdb_pc, 32'd0);
    checkVal({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkVal({tag, "_ovf"}, {31'd0, wbq_overflow}, 32'd0);
  endtask

  initial begin
    logic [6:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b0;
    issue_pkt = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("por");
    @(negedge clk);
    reset = 1'b1;

    // Single ADD, visible exactly one cycle at c3
    applyStimulus(mkPkt(7'h01, 32'h100, 7'd3, 32'd5, 32'd7));
    applyStimulus('0);
    applyStimulus('0);
    checkVal("add_valid", {31'd0, ALU_result_valid}, 32'd1);
    checkVal("add_result", ALU_result, 32'd12);
    checkVal("add_dest", {25'd0, ALU_result_dest}, 32'd3);
    applyStimulus('0);
    checkVal("add_one_cycle", {31'd0, ALU_result_valid}, 32'd0);

    // Bubbles only
    for (int i = 0; i < 20; i++) begin
      applyStimulus('0);
      checkVal("bubble_valid", {31'd0, ALU_result_valid}, 32'd0);
      checkVal("bubble_busy", {31'd0, busy}, 32'd0);
    end

    // MUL then younger ADD completing on the same edge
    applyStimulus(mkPkt(7'h0B, 32'h200, 7'd9, 32'h0000FFFF, 32'h00010001));
    applyStimulus('0);
    applyStimulus(mkPkt(7'h01, 32'h208, 7'd4, 32'd1, 32'd1));
    applyStimulus('0);
    applyStimulus('0);
    checkVal("mul_result", ALU_result, 32'hFFFFFFFF);
    checkVal("mul_dest", {25'd0, ALU_result_dest}, 32'd9);
    applyStimulus('0);
    checkVal("mul_add_result", ALU_result, 32'd2);
    checkVal("mul_add_dest", {25'd0, ALU_result_dest}, 32'd4);
    checkVal("mul_add_ovf", {31'd0, wbq_overflow}, 32'd0);
    repeat (4) applyStimulus('0);

    // Eight back-to-back ADDs
    for (int i = 0; i < 11; i++) begin
      applyStimulus((i < 8) ? mkPkt(7'h01, 32'h300 + 32'(4 * i), 7'(i + 1), 32'(i), 32'd1) : '0);
      if (i >= 2 && i <= 9) begin
        checkVal("b2b_valid", {31'd0, ALU_result_valid}, 32'd1);
        checkVal("b2b_dest", {25'd0, ALU_result_dest}, 32'(i - 1));
      end
    end
    repeat (3) applyStimulus('0);

    // Boundary ALU cases
    applyStimulus(mkPkt(7'h08, 32'h400, 7'd10, 32'h80000000, 32'd4));
    applyStimulus(mkPkt(7'h09, 32'h404, 7'd11, 32'hFFFFFFFF, 32'd1));
    applyStimulus(mkPkt(7'h0A, 32'h408, 7'd12, 32'hFFFFFFFF, 32'd1));
    checkVal("sra_result", ALU_result, 32'hF8000000);
    applyStimulus(mkPkt(7'h7F, 32'h40C, 7'd13, 32'h12345678, 32'h9ABCDEF0));
    checkVal("slt_result", ALU_result, 32'd1);
    applyStimulus('0);
    checkVal("sltu_result", ALU_result, 32'd0);
    applyStimulus('0);
    checkVal("badop_result", ALU_result, 32'd0);
    checkVal("badop_valid", {31'd0, ALU_result_valid}, 32'd1);
    checkVal("badop_dest", {25'd0, ALU_result_dest}, 32'd13);
    repeat (3) applyStimulus('0);

    // Reset with work in flight
    applyStimulus(mkPkt(7'h01, 32'h500, 7'd20, 32'd3, 32'd4));
    applyStimulus(mkPkt(7'h0B, 32'h504, 7'd21, 32'd3, 32'd4));
    issue_pkt = '0;
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("rst_async");
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0);
      checkVal("post_rst_valid", {31'd0, ALU_result_valid}, 32'd0);
    end

    // Random issue traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 15))
        0, 1, 2: rop = 7'h00;
        3:       rop = 7'h7F;
        default: rop = 7'($urandom_range(1, 11));
      endcase
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      applyStimulus(mkPkt(rop, $urandom(), 7'($urandom_range(0, 127)), ra, rb));
    end
    repeat (12) applyStimulus('0);
    checkVal("final_ovf", {31'd0, wbq_overflow}, 32'd0);
    checkVal("final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
